// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and defaults for the decode/execute issue scoreboard.
//   slot_t      : one in-flight writer record {valid, rd, write, is_load}
//   DEPTH_DEF   : number of tracked slots after decode (EX, MEM, WB)
//   ALU_READY_DEF / LOAD_READY_DEF : lowest slot index from which a result
//                 can be forwarded for non-load / load producers
//   REG_ZERO    : architectural zero register address
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int DEPTH_DEF      = 3;
    localparam int ALU_READY_DEF  = 0;
    localparam int LOAD_READY_DEF = 1;

    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       write;
        logic       is_load;
    } slot_t;

    // Lowest slot index at which a producer's value can be forwarded.
    function automatic int ready_index(input logic is_load,
                                       input int   alu_ready,
                                       input int   load_ready);
        return is_load ? load_ready : alu_ready;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_lookup.sv
// ----------------------------------------------------------------------------
// scoreboard_lookup
//   Resolves one decode source operand against the in-flight slot array.
//   Finds the youngest (lowest index) slot that writes the source register
//   and reports whether that producer's value is not yet forwardable.
// Ports
//   slots        in  DEPTH x slot_t  tracker contents, index 0 = EX
//   src_address  in  5               source register address
//   src_used     in  1               instruction actually reads the source
//   not_ready    out 1               youngest producer cannot forward yet
// ----------------------------------------------------------------------------
module scoreboard_lookup
    import hazard_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ALU_READY  = ALU_READY_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic  [4:0]       src_address,
    input  logic              src_used,
    output logic              not_ready
);

    logic             src_live;
    logic [DEPTH-1:0] match;

    assign src_live = src_used && (src_address != REG_ZERO);

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = src_live && slots[k].valid && slots[k].write
                       && (slots[k].rd == src_address);
        end
    end

    // Only the youngest match decides; a ready younger producer hides an
    // older one because its value is the architecturally newer one.
    always_comb begin
        logic found;
        found     = 1'b0;
        not_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && match[k]) begin
                found     = 1'b1;
                not_ready = (k < ready_index(slots[k].is_load,
                                             ALU_READY, LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//   Issue controller between decode and execute. Keeps a DEPTH-slot shift
//   tracker of in-flight register writers (slot 0 = EX, DEPTH-1 = WB) and
//   stalls decode on RAW hazards that forwarding cannot cover.
//   Priority each cycle: hold_i > flush_i > hazard > normal issue.
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   dec_valid_i            decode holds a valid instruction
//   dec_rs1/rs2_address_i  source registers, dec_rs1/rs2_used_i read flags
//   dec_rd_address_i       destination, dec_rd_write_i writes rd
//   dec_is_load_i          instruction is a load
//   hold_i                 downstream stall, freezes the tracker
//   flush_i                kill the instruction in decode
//   issue_o                decode instruction enters EX this cycle
//   dec_stall_o            decode/fetch hold their registers
//   stall_count_o          hazard-stall cycle counter (wraps)
// ----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ALU_READY  = ALU_READY_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    input  logic [4:0]  dec_rs1_address_i,
    input  logic [4:0]  dec_rs2_address_i,
    input  logic        dec_rs1_used_i,
    input  logic        dec_rs2_used_i,
    input  logic [4:0]  dec_rd_address_i,
    input  logic        dec_rd_write_i,
    input  logic        dec_is_load_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic        issue_o,
    output logic        dec_stall_o,
    output logic [31:0] stall_count_o
);

    slot_t [DEPTH-1:0] slots;
    slot_t             new_slot;
    logic              rs1_not_ready;
    logic              rs2_not_ready;
    logic              hazard;
    logic [31:0]       stall_count;

    scoreboard_lookup #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY)
    ) u_lookup_rs1 (
        .slots       (slots),
        .src_address (dec_rs1_address_i),
        .src_used    (dec_rs1_used_i),
        .not_ready   (rs1_not_ready)
    );

    scoreboard_lookup #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY)
    ) u_lookup_rs2 (
        .slots       (slots),
        .src_address (dec_rs2_address_i),
        .src_used    (dec_rs2_used_i),
        .not_ready   (rs2_not_ready)
    );

    assign hazard = dec_valid_i && (rs1_not_ready || rs2_not_ready);

    // Writes to x0 are recorded as non-writers so they can never match.
    always_comb begin
        new_slot         = '0;
        new_slot.valid   = dec_valid_i;
        new_slot.rd      = dec_rd_address_i;
        new_slot.write   = dec_rd_write_i && (dec_rd_address_i != REG_ZERO);
        new_slot.is_load = dec_is_load_i;
    end

    always_comb begin
        issue_o     = 1'b0;
        dec_stall_o = 1'b0;
        if (hold_i) begin
            dec_stall_o = 1'b1;
        end else if (flush_i) begin
            dec_stall_o = 1'b0;
        end else if (hazard) begin
            dec_stall_o = 1'b1;
        end else begin
            issue_o = dec_valid_i;
        end
    end

    // The tracker advances every cycle that is not held; a flushed or
    // stalled instruction becomes a bubble in EX while older writers keep
    // moving toward retirement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots       <= '0;
            stall_count <= '0;
        end else if (!hold_i) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slots[i] <= slots[i-1];
            end
            if (flush_i || hazard) begin
                slots[0] <= '0;
            end else begin
                slots[0] <= new_slot;
            end
            if (!flush_i && hazard) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    assign stall_count_o = stall_count;

endmodule
